// File: rtl/monopix_pkg.sv
// Shared types and helpers for the MONOPIX end-of-column readout blocks.
// Word layout is {col, te, le, row}, 27 bits, shifted out MSB first.
package monopix_pkg;

  localparam int unsigned WORD_W = 27;
  localparam int unsigned CNT_W  = 5;

  typedef struct packed {
    logic [5:0] col;
    logic [5:0] te;
    logic [5:0] le;
    logic [8:0] row;
  } t_data;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } t_tx_state;

  function automatic logic [5:0] gray_enc(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/monopix_eoc_tx_if.sv
// Hit-word handshake between the column logic (master) and the EOC transmitter (slave).
interface monopix_eoc_tx_if;

  logic       hit_valid;
  logic       hit_ready;
  logic [5:0] hit_col;
  logic [5:0] hit_le;
  logic [5:0] hit_te;
  logic [8:0] hit_row;

  modport master (
    output hit_valid,
    output hit_col,
    output hit_le,
    output hit_te,
    output hit_row,
    input  hit_ready
  );

  modport slave (
    input  hit_valid,
    input  hit_col,
    input  hit_le,
    input  hit_te,
    input  hit_row,
    output hit_ready
  );

endinterface

// File: rtl/monopix_eoc_fifo.sv
// Synchronous FIFO of hit words with a combinational head and async active-low reset.
// Storage is not reset; only the pointers and level are, which empties the FIFO.
module monopix_eoc_fifo
  import monopix_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_out,
  input  logic                   rst_n,
  input  logic                   push,
  input  t_data                  wdata,
  input  logic                   pop,
  output t_data                  head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  t_data            mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_out) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      // Simultaneous push and pop leaves the level unchanged.
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/monopix_eoc_tx.sv
// MONOPIX end-of-column serial transmitter: buffers hit words, raises token, shifts one
// word per synchronised read edge. Define MONOPIX_EOC_TX_GRAY_EN to Gray-code le/te on push.
module monopix_eoc_tx
  import monopix_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk_out,
  input  logic                    rst_n,
  monopix_eoc_tx_if.slave         hit,
  input  logic                    read,
  input  logic                    freeze,
  output logic                    token,
  output logic                    data_out,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  logic [1:0]        read_s_q;
  logic              read_q;
  logic [1:0]        freeze_s_q;
  logic              read_edge;

  t_tx_state         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              data_out_q, data_out_d;
  logic              token_q;

  logic              hit_ready;
  logic              push;
  logic              pop;
  t_data             push_data;
  t_data             head;
  logic              full;
  logic              empty;
  logic [WORD_W-1:0] load_word;

  assign read_edge     = read_s_q[1] & ~read_q;
  assign hit_ready     = ~full & ~freeze_s_q[1];
  assign hit.hit_ready = hit_ready;
  assign push          = hit.hit_valid & hit_ready;

  always_comb begin
    push_data.col = hit.hit_col;
    push_data.row = hit.hit_row;
`ifdef MONOPIX_EOC_TX_GRAY_EN
    push_data.le  = gray_enc(hit.hit_le);
    push_data.te  = gray_enc(hit.hit_te);
`else
    push_data.le  = hit.hit_le;
    push_data.te  = hit.hit_te;
`endif
  end

  monopix_eoc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .push    (push),
    .wdata   (push_data),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    data_out_d = data_out_q;
    pop        = 1'b0;
    load_word  = '0;
    unique case (state_q)
      StIdle: begin
        if (read_edge) begin
          // An empty FIFO still answers the read, with an all-zero word.
          if (!empty) begin
            pop       = 1'b1;
            load_word = head;
          end
          state_d    = StShift;
          cnt_d      = CNT_W'(WORD_W - 1);
          sreg_d     = load_word;
          data_out_d = load_word[WORD_W-1];
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
          state_d    = StIdle;
          data_out_d = 1'b0;
        end else begin
          sreg_d     = sreg_q << 1;
          data_out_d = sreg_q[WORD_W-2];
          cnt_d      = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      read_s_q   <= '0;
      read_q     <= 1'b0;
      freeze_s_q <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      sreg_q     <= '0;
      data_out_q <= 1'b0;
      token_q    <= 1'b0;
    end else begin
      read_s_q   <= {read_s_q[0], read};
      read_q     <= read_s_q[1];
      freeze_s_q <= {freeze_s_q[0], freeze};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      data_out_q <= data_out_d;
      token_q    <= ~empty;
    end
  end

  assign data_out = data_out_q;
  assign token    = token_q;
  assign busy     = (state_q == StShift);

endmodule

// File: tb/tb_monopix_eoc_tx.sv
// Directed self-checking bench for monopix_eoc_tx: reset, single word, empty read,
// fill/freeze, ordered drain, ignored read, push-during-pop and mid-shift reset.
module tb_monopix_eoc_tx;

  localparam int unsigned DEPTH = 8;
`ifdef MONOPIX_EOC_TX_GRAY_EN
  localparam logic [26:0] SingleExp = 27'h468E0A;
`else
  localparam logic [26:0] SingleExp = 27'h448A0A;
`endif

  logic       clk_out = 1'b0;
  logic       rst_n   = 1'b0;
  logic       read    = 1'b0;
  logic       freeze  = 1'b0;
  logic       token;
  logic       data_out;
  logic       busy;
  logic [3:0] fifo_level;

  int n_checks = 0;
  int n_pass   = 0;

  monopix_eoc_tx_if hit_bus ();

  monopix_eoc_tx #(
    .DEPTH (DEPTH)
  ) dut (
    .clk_out    (clk_out),
    .rst_n      (rst_n),
    .hit        (hit_bus),
    .read       (read),
    .freeze     (freeze),
    .token      (token),
    .data_out   (data_out),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk_out = ~clk_out;

  function automatic logic [26:0] exp_word(input logic [5:0] c, input logic [5:0] l,
                                           input logic [5:0] t, input logic [8:0] r);
`ifdef MONOPIX_EOC_TX_GRAY_EN
    l = l ^ (l >> 1);
    t = t ^ (t >> 1);
`endif
    return {c, t, l, r};
  endfunction

  task automatic push_word(input logic [5:0] c, input logic [5:0] l, input logic [5:0] t,
                           input logic [8:0] r);
    @(posedge clk_out);
    #2;
    hit_bus.hit_valid = 1'b1;
    hit_bus.hit_col   = c;
    hit_bus.hit_le    = l;
    hit_bus.hit_te    = t;
    hit_bus.hit_row   = r;
    @(posedge clk_out);
    #1;
    hit_bus.hit_valid = 1'b0;
  endtask

  // Raises read so that the next clk_out edge is E0, captures bits at E2..E28 (+1),
  // returns at E29+1. Optionally re-pulses read mid-shift or pushes a word at E2.
  task automatic read_capture(input bit reread, input bit push_e2, input logic [5:0] pc,
                              input logic [5:0] pl, input logic [5:0] pt,
                              input logic [8:0] pr, output logic [26:0] word,
                              output logic tok_e2, output logic tok_e3,
                              output logic [3:0] lvl_e2, output int busy_cnt);
    word     = '0;
    busy_cnt = 0;
    tok_e3   = 1'bx;
    @(posedge clk_out);
    #2 read = 1'b1;
    @(posedge clk_out);
    @(posedge clk_out);
    if (push_e2) begin
      #2;
      hit_bus.hit_valid = 1'b1;
      hit_bus.hit_col   = pc;
      hit_bus.hit_le    = pl;
      hit_bus.hit_te    = pt;
      hit_bus.hit_row   = pr;
    end
    @(posedge clk_out);
    #1;
    hit_bus.hit_valid = 1'b0;
    tok_e2 = token;
    lvl_e2 = fifo_level;
    for (int i = 26; i >= 0; i--) begin
      word[i] = data_out;
      if (busy) busy_cnt++;
      if (i == 25) tok_e3 = token;
      if (i == 21) read = 1'b0;
      if (reread && i == 15) read = 1'b1;
      if (reread && i == 10) read = 1'b0;
      @(posedge clk_out);
      #1;
    end
    if (busy) busy_cnt++;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (data_out !== 1'b0) $display("FAIL reset_data_out: got %b want 0", data_out);
    else n_pass++;
    n_checks++;
    if (token !== 1'b0) $display("FAIL reset_token: got %b want 0", token);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (fifo_level !== 4'd0) $display("FAIL reset_level: got %0d want 0", fifo_level);
    else n_pass++;
    #12 rst_n = 1'b1;
    @(posedge clk_out);
    #1;
    n_checks++;
    if (hit_bus.hit_ready !== 1'b1)
      $display("FAIL reset_hit_ready: got %b want 1", hit_bus.hit_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [26:0] w;
    logic        t2, t3;
    logic [3:0]  lv;
    int          bc;
    push_word(6'd2, 6'd5, 6'd9, 9'd10);
    n_checks++;
    if (fifo_level !== 4'd1) $display("FAIL single_level_push: got %0d want 1", fifo_level);
    else n_pass++;
    n_checks++;
    if (token !== 1'b0) $display("FAIL single_token_push_edge: got %b want 0", token);
    else n_pass++;
    @(posedge clk_out);
    #1;
    n_checks++;
    if (token !== 1'b1) $display("FAIL single_token_rise: got %b want 1", token);
    else n_pass++;
    read_capture(1'b0, 1'b0, '0, '0, '0, '0, w, t2, t3, lv, bc);
    n_checks++;
    if (w !== SingleExp) $display("FAIL single_word: got %h want %h", w, SingleExp);
    else n_pass++;
    n_checks++;
    if (t2 !== 1'b1) $display("FAIL single_token_e2: got %b want 1", t2);
    else n_pass++;
    n_checks++;
    if (t3 !== 1'b0) $display("FAIL single_token_e3: got %b want 0", t3);
    else n_pass++;
    n_checks++;
    if (data_out !== 1'b0) $display("FAIL single_data_out_tail: got %b want 0", data_out);
    else n_pass++;
    n_checks++;
    if (bc !== 27) $display("FAIL single_busy_cycles: got %0d want 27", bc);
    else n_pass++;
  endtask

  task automatic test_empty_read();
    logic [26:0] w;
    logic        t2, t3;
    logic [3:0]  lv;
    int          bc;
    read_capture(1'b0, 1'b0, '0, '0, '0, '0, w, t2, t3, lv, bc);
    n_checks++;
    if (w !== 27'd0) $display("FAIL empty_word: got %h want 0", w);
    else n_pass++;
    n_checks++;
    if (bc !== 27) $display("FAIL empty_busy_cycles: got %0d want 27", bc);
    else n_pass++;
    n_checks++;
    if (fifo_level !== 4'd0 || lv !== 4'd0)
      $display("FAIL empty_level: got %0d/%0d want 0", lv, fifo_level);
    else n_pass++;
  endtask

  task automatic test_fill_freeze();
    logic [26:0] w;
    logic        t2, t3;
    logic [3:0]  lv;
    int          bc;
    for (int i = 0; i < 8; i++) push_word(6'(i), 6'(i), 6'(i), 9'(100 + i));
    n_checks++;
    if (fifo_level !== 4'd8) $display("FAIL fill_level: got %0d want 8", fifo_level);
    else n_pass++;
    n_checks++;
    if (hit_bus.hit_ready !== 1'b0)
      $display("FAIL fill_ready_full: got %b want 0", hit_bus.hit_ready);
    else n_pass++;
    @(posedge clk_out);
    #2 freeze = 1'b1;
    read_capture(1'b0, 1'b0, '0, '0, '0, '0, w, t2, t3, lv, bc);
    n_checks++;
    if (w !== exp_word(6'd0, 6'd0, 6'd0, 9'd100))
      $display("FAIL freeze_pop_word: got %h want %h", w, exp_word(6'd0, 6'd0, 6'd0, 9'd100));
    else n_pass++;
    n_checks++;
    if (hit_bus.hit_ready !== 1'b0)
      $display("FAIL freeze_ready_after_pop: got %b want 0", hit_bus.hit_ready);
    else n_pass++;
    push_word(6'd55, 6'd1, 6'd1, 9'd1);
    n_checks++;
    if (fifo_level !== 4'd7) $display("FAIL freeze_push_blocked: got %0d want 7", fifo_level);
    else n_pass++;
    @(posedge clk_out);
    #2 freeze = 1'b0;
    @(posedge clk_out);
    #1;
    n_checks++;
    if (hit_bus.hit_ready !== 1'b0)
      $display("FAIL unfreeze_ready_e0: got %b want 0", hit_bus.hit_ready);
    else n_pass++;
    @(posedge clk_out);
    #1;
    n_checks++;
    if (hit_bus.hit_ready !== 1'b1)
      $display("FAIL unfreeze_ready_e1: got %b want 1", hit_bus.hit_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [26:0] w;
    logic [26:0] ew;
    logic        t2, t3;
    logic [3:0]  lv;
    int          bc;
    for (int i = 1; i < 8; i++) begin
      read_capture(1'b0, 1'b0, '0, '0, '0, '0, w, t2, t3, lv, bc);
      ew = exp_word(6'(i), 6'(i), 6'(i), 9'(100 + i));
      n_checks++;
      if (w !== ew) $display("FAIL b2b_word%0d: got %h want %h", i, w, ew);
      else n_pass++;
      n_checks++;
      if (t3 !== (i != 7)) $display("FAIL b2b_token%0d: got %b want %b", i, t3, (i != 7));
      else n_pass++;
      repeat (4) @(posedge clk_out);
    end
    #1;
    n_checks++;
    if (fifo_level !== 4'd0 || token !== 1'b0)
      $display("FAIL b2b_drained: got level %0d token %b want 0 0", fifo_level, token);
    else n_pass++;
  endtask

  task automatic test_ignored_read();
    logic [26:0] w;
    logic        t2, t3;
    logic [3:0]  lv;
    int          bc;
    push_word(6'd10, 6'd11, 6'd12, 9'd13);
    push_word(6'd20, 6'd21, 6'd22, 9'd23);
    read_capture(1'b1, 1'b0, '0, '0, '0, '0, w, t2, t3, lv, bc);
    n_checks++;
    if (w !== exp_word(6'd10, 6'd11, 6'd12, 9'd13))
      $display("FAIL ignored_word: got %h want %h", w, exp_word(6'd10, 6'd11, 6'd12, 9'd13));
    else n_pass++;
    repeat (6) @(posedge clk_out);
    #1;
    n_checks++;
    if (busy !== 1'b0 || fifo_level !== 4'd1)
      $display("FAIL ignored_read_started: got busy %b level %0d want 0 1", busy, fifo_level);
    else n_pass++;
  endtask

  task automatic test_push_pop();
    logic [26:0] w;
    logic        t2, t3;
    logic [3:0]  lv;
    int          bc;
    read_capture(1'b0, 1'b1, 6'd30, 6'd31, 6'd32, 9'd33, w, t2, t3, lv, bc);
    n_checks++;
    if (w !== exp_word(6'd20, 6'd21, 6'd22, 9'd23))
      $display("FAIL pushpop_word: got %h want %h", w, exp_word(6'd20, 6'd21, 6'd22, 9'd23));
    else n_pass++;
    n_checks++;
    if (lv !== 4'd1) $display("FAIL pushpop_level: got %0d want 1", lv);
    else n_pass++;
    n_checks++;
    if (t3 !== 1'b1) $display("FAIL pushpop_token: got %b want 1", t3);
    else n_pass++;
    repeat (4) @(posedge clk_out);
    read_capture(1'b0, 1'b0, '0, '0, '0, '0, w, t2, t3, lv, bc);
    n_checks++;
    if (w !== exp_word(6'd30, 6'd31, 6'd32, 9'd33))
      $display("FAIL pushpop_word2: got %h want %h", w, exp_word(6'd30, 6'd31, 6'd32, 9'd33));
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [26:0] w;
    logic        t2, t3;
    logic [3:0]  lv;
    int          bc;
    push_word(6'd63, 6'd16, 6'd63, 9'd0);
    push_word(6'd1, 6'd1, 6'd1, 9'd1);
    @(posedge clk_out);
    #2 read = 1'b1;
    repeat (3) @(posedge clk_out);
    repeat (13) @(posedge clk_out);
    #1;
    n_checks++;
    if (data_out !== 1'b1 || busy !== 1'b1)
      $display("FAIL midrst_bit13: got data %b busy %b want 1 1", data_out, busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (data_out !== 1'b0 || token !== 1'b0 || fifo_level !== 4'd0 || busy !== 1'b0)
      $display("FAIL midrst_clear: got data %b token %b level %0d busy %b want 0 0 0 0",
               data_out, token, fifo_level, busy);
    else n_pass++;
    read = 1'b0;
    #20 rst_n = 1'b1;
    read_capture(1'b0, 1'b0, '0, '0, '0, '0, w, t2, t3, lv, bc);
    n_checks++;
    if (w !== 27'd0 || bc !== 27)
      $display("FAIL midrst_after_read: got word %h busy %0d want 0 27", w, bc);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hit_bus.hit_valid = 1'b0;
    hit_bus.hit_col   = '0;
    hit_bus.hit_le    = '0;
    hit_bus.hit_te    = '0;
    hit_bus.hit_row   = '0;
    test_reset();
    test_single();
    test_empty_read();
    test_fill_freeze();
    test_back_to_back();
    test_ignored_read();
    test_push_pop();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
